// File: rtl/lift_scan_if.sv
// rtl/lift_scan_if.sv - call strobe in, car status out, for the lift scan controller
interface lift_scan_if #(
  parameter int N_FLOORS = 9
);
  localparam int FW = ($clog2(N_FLOORS) < 1) ? 1 : $clog2(N_FLOORS);

  logic                REQ_VALID;
  logic [FW-1:0]       REQ_FLOOR;
  logic [N_FLOORS-1:0] PENDING;
  logic [FW-1:0]       FLOOR;
  logic [1:0]          MOVIMENTO;
  logic                LED_G;
  logic                LED_R;
  logic                ARRIVED;

  modport master (
    output REQ_VALID, REQ_FLOOR,
    input  PENDING, FLOOR, MOVIMENTO, LED_G, LED_R, ARRIVED
  );

  modport slave (
    input  REQ_VALID, REQ_FLOOR,
    output PENDING, FLOOR, MOVIMENTO, LED_G, LED_R, ARRIVED
  );
endinterface

// File: rtl/lift_scan_controller.sv
// rtl/lift_scan_controller.sv - SCAN lift controller: latches calls, times travel and door, serves stops in sweep order
module lift_scan_controller #(
  parameter int N_FLOORS    = 9,
  parameter int FLOOR_TICKS = 50000000,
  parameter int DOOR_TICKS  = 100000000
) (
  input logic        CLOCK_50,
  input logic        RESET,
  lift_scan_if.slave bus
);
  localparam int FW = ($clog2(N_FLOORS) < 1) ? 1 : $clog2(N_FLOORS);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t              state;
  logic                dir_up;
  logic [FW-1:0]       floor_q;
  logic [N_FLOORS-1:0] pending;
  logic [31:0]         travel_cnt;
  logic [31:0]         door_cnt;
  logic [1:0]          movimento;
  logic                led_g;
  logic                arrived;

  logic [N_FLOORS-1:0] above, below, set_bits, served_bit;
  logic [FW-1:0]       next_floor;
  logic                req_ok, req_here, at_top, at_bottom, at_end;
  logic                eff_up, ahead, behind, stop_here;

  always_comb begin
    above = '0;
    below = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      above[i] = (i > int'(floor_q));
      below[i] = (i < int'(floor_q));
    end
    req_ok   = bus.REQ_VALID && (int'(bus.REQ_FLOOR) < N_FLOORS);
    req_here = req_ok && (bus.REQ_FLOOR == floor_q);
    // A call for the floor the car stands on is answered by the door, not latched
    set_bits = '0;
    if (req_ok && !(req_here && state != MOVE))
      set_bits = N_FLOORS'(1) << bus.REQ_FLOOR;
    at_top     = (floor_q == FW'(N_FLOORS - 1));
    at_bottom  = (floor_q == '0);
    eff_up     = at_bottom || (!at_top && dir_up);
    ahead      = eff_up ? |(pending & above) : |(pending & below);
    behind     = eff_up ? |(pending & below) : |(pending & above);
    next_floor = dir_up ? floor_q + FW'(1) : floor_q - FW'(1);
    at_end     = dir_up ? at_top : at_bottom;
    served_bit = N_FLOORS'(1) << next_floor;
    stop_here  = !at_end && |(pending & served_bit);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state      <= IDLE;
      dir_up     <= 1'b1;
      floor_q    <= '0;
      pending    <= '0;
      travel_cnt <= '0;
      door_cnt   <= '0;
      movimento  <= 2'd0;
      led_g      <= 1'b0;
      arrived    <= 1'b0;
    end else begin
      arrived <= 1'b0;
      pending <= pending | set_bits;
      case (state)
        IDLE: begin
          if (req_here) begin
            state    <= DOOR;
            led_g    <= 1'b1;
            door_cnt <= '0;
          end else if (ahead || behind) begin
            dir_up     <= ahead ? eff_up : ~eff_up;
            movimento  <= (ahead ? eff_up : ~eff_up) ? 2'd1 : 2'd2;
            travel_cnt <= '0;
            state      <= MOVE;
          end
        end
        MOVE: begin
          if (at_end) begin
            state      <= IDLE;
            movimento  <= 2'd0;
            travel_cnt <= '0;
          end else if (travel_cnt == 32'(FLOOR_TICKS - 1)) begin
            travel_cnt <= '0;
            floor_q    <= next_floor;
            if (stop_here) begin
              // Clear overrides a same-cycle set: this arrival serves that call
              pending   <= (pending | set_bits) & ~served_bit;
              arrived   <= 1'b1;
              led_g     <= 1'b1;
              door_cnt  <= '0;
              movimento <= 2'd0;
              state     <= DOOR;
            end
          end else begin
            travel_cnt <= travel_cnt + 32'd1;
          end
        end
        DOOR: begin
          if (req_here) begin
            door_cnt <= '0;
          end else if (door_cnt == 32'(DOOR_TICKS - 1)) begin
            led_g    <= 1'b0;
            door_cnt <= '0;
            state    <= IDLE;
          end else begin
            door_cnt <= door_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.PENDING   = pending;
  assign bus.FLOOR     = floor_q;
  assign bus.MOVIMENTO = movimento;
  assign bus.LED_G     = led_g;
  assign bus.LED_R     = ~led_g;
  assign bus.ARRIVED   = arrived;
endmodule

// File: doc/lift_scan_controller.md
LIFT_SCAN_CONTROLLER -- requirements
Module: lift_scan_controller

Interface
REQ-001 The block SHALL have parameter N_FLOORS, default 9, meaning the number of served floors (range 2..16).
REQ-002 The block SHALL have parameter FLOOR_TICKS, default 50000000, meaning CLOCK_50 cycles of travel per floor.
REQ-003 The block SHALL have parameter DOOR_TICKS, default 100000000, meaning CLOCK_50 cycles the door stays open.
REQ-004 The block SHALL have localparam FW = clog2(N_FLOORS), minimum 1, meaning the floor index width.
REQ-005 The block SHALL have port CLOCK_50, input, width 1: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port RESET, input, width 1: reset, synchronous and active-high.
REQ-007 The block SHALL have port REQ_VALID, input, width 1: a one-cycle call strobe.
REQ-008 The block SHALL have port REQ_FLOOR, input, width FW: the called floor, sampled when REQ_VALID=1.
REQ-009 The block SHALL have port PENDING, output, width N_FLOORS: latched calls, bit i meaning floor i.
REQ-010 The block SHALL have port FLOOR, output, width FW: the current floor, binary.
REQ-011 The block SHALL have port MOVIMENTO, output, width 2: 0 = parado, 1 = subindo, 2 = descendo; 3 is never driven.
REQ-012 The block SHALL have port LED_G, output, width 1: door open.
REQ-013 The block SHALL have port LED_R, output, width 1: door closed; always equals ~LED_G.
REQ-014 The block SHALL have port ARRIVED, output, width 1: a one-cycle pulse when a stop is served.

Function
REQ-015 The FSM SHALL have states IDLE, MOVE and DOOR, plus a direction register DIR (UP/DOWN).
REQ-016 On REQ_VALID=1 with REQ_FLOOR < N_FLOORS, the block SHALL set PENDING[REQ_FLOOR] next cycle, except as stated in REQ-017; REQ_FLOOR >= N_FLOORS SHALL be ignored.
REQ-017 A call for FLOOR while in IDLE or DOOR SHALL not set PENDING: IDLE goes to DOOR next cycle; DOOR restarts the door timer.
REQ-018 In IDLE with a pending call strictly ahead in DIR, the block SHALL enter MOVE next cycle with DIR unchanged.
REQ-019 Otherwise, in IDLE with a pending call only behind, the block SHALL invert DIR and enter MOVE next cycle.
REQ-020 With PENDING=0, the block SHALL remain in IDLE.
REQ-021 In MOVE, the travel counter SHALL count 0..FLOOR_TICKS-1; at terminal count FLOOR SHALL step by ±1 per DIR, so FLOOR changes exactly FLOOR_TICKS cycles after MOVE entry.
REQ-022 On reaching floor f with PENDING[f]=1, the block SHALL clear PENDING[f], pulse ARRIVED for 1 cycle and enter DOOR; otherwise it SHALL restart the counter and continue.
REQ-023 In DOOR, LED_G SHALL be 1 for exactly DOOR_TICKS cycles, then the block SHALL return to IDLE.
REQ-024 MOVIMENTO SHALL be 1 or 2 only in MOVE (per DIR) and 0 in IDLE and DOOR.
REQ-025 FLOOR SHALL never leave 0..N_FLOORS-1; DIR SHALL be forced UP at floor 0 and DOWN at floor N_FLOORS-1 before a move.
REQ-026 If a set and a clear of the same PENDING bit occur in the same cycle, clear SHALL win (the call is served by that arrival).
REQ-027 Calls arriving during MOVE SHALL be served en route if ahead of the car in DIR and not yet passed; otherwise they SHALL be served after reversal.

Reset
REQ-028 RESET=1 at an edge SHALL force, from the next cycle: state IDLE, DIR UP, FLOOR=0, PENDING=0, MOVIMENTO=0, LED_G=0, LED_R=1, ARRIVED=0, and both timers 0.
REQ-029 RESET SHALL take priority over REQ_VALID and over any in-progress move or door cycle (reset mid-move SHALL abandon the move; the car reads floor 0).

Verification (N_FLOORS=9, FLOOR_TICKS=4, DOOR_TICKS=3)
REQ-030 The bench SHALL check: reset, call 3 -> PENDING=0x008, MOVIMENTO=1; FLOOR 1/2/3 at +4/+8/+12 cycles; ARRIVED pulse, PENDING=0, LED_G=1 for 3 cycles; then IDLE, MOVIMENTO=0.
REQ-031 The bench SHALL check: car idle at 3 after an upward trip, calls 1 and 5 in consecutive cycles -> serves 5 first (MOVIMENTO=1), then 1 (MOVIMENTO=2).
REQ-032 The bench SHALL check: call for the current floor 0 while idle -> LED_G=1 next cycle, PENDING stays 0, ARRIVED stays 0.
REQ-033 The bench SHALL check: REQ_FLOOR=9 and 15 -> PENDING unchanged, FSM stays IDLE.
REQ-034 The bench SHALL check: call 8, then RESET asserted at FLOOR=2 mid-move -> next cycle FLOOR=0, PENDING=0, MOVIMENTO=0, LED_R=1.
REQ-035 The bench SHALL check: car moving up from 0 toward 6, call 4 issued while FLOOR=1 -> stops at 4 (ARRIVED), door cycle, resumes to 6.
